// File: rtl/uart_baud_gen_pkg.sv
// uart_baud_pkg: shared types and elaboration-time helpers for the baud
// generator. Holds the run-time rate table and the phase-increment function
// used to build the per-rate accumulator step at elaboration.
package uart_baud_pkg;

  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] baud_sel_t;

  localparam int unsigned BAUD_RATES [0:7] = '{
    2400, 4800, 9600, 19200, 38400, 57600, 115200, 230400
  };

  // round(rate * os * 2^acc_w / freq); only ever evaluated on constants.
  function automatic longint unsigned baud_inc(
    input longint unsigned rate,
    input longint unsigned os,
    input int              acc_w,
    input longint unsigned freq
  );
    longint unsigned num;
    num = (rate * os) << acc_w;
    return (num + freq / 2) / freq;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// uart_baud_gen_if: control and tick bundle between a UART and its baud
// generator.
//   master: drives en, restart, baud_sel; receives the ticks.
//   slave : the generator; drives rx_tick, tx_tick, os_idx, baud_level.
interface uart_baud_gen_if #(
  parameter int OVERSAMPLE = 16
);
  import uart_baud_pkg::*;

  localparam int OS_W = $clog2(OVERSAMPLE);

  logic            en;
  logic            restart;
  baud_sel_t       baud_sel;
  logic            rx_tick;
  logic            tx_tick;
  logic [OS_W-1:0] os_idx;
  logic            baud_level;

  modport master (
    output en, restart, baud_sel,
    input  rx_tick, tx_tick, os_idx, baud_level
  );

  modport slave (
    input  en, restart, baud_sel,
    output rx_tick, tx_tick, os_idx, baud_level
  );

endinterface

// File: rtl/uart_baud_gen_phase_acc.sv
// baud_phase_acc: ACC_W-bit fractional phase accumulator.
//   clk, arst_n : clock, async active-low reset
//   clr         : synchronous clear to phase 0 (wins over en)
//   en          : advance by inc this cycle
//   inc         : phase step
//   carry       : combinational overflow of this cycle's add (0 when
//                 cleared or disabled)
module baud_phase_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc};
    acc_d = acc_q;
    carry = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[ACC_W-1:0];
      carry = sum[ACC_W];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) acc_q <= '0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: fractional baud-rate generator with oversampled rx tick.
//   clk, arst_n : clock, async active-low reset
//   bus (slave) : en, restart, baud_sel in; rx_tick, tx_tick, os_idx,
//                 baud_level out (all registered)
// A rate change is treated exactly like a restart so the first bit at the
// new rate always starts from phase 0.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 24
) (
  input  logic           clk,
  input  logic           arst_n,
  uart_baud_gen_if.slave bus
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [ACC_W-1:0] inc_tbl [0:(2**SEL_W)-1];

  for (genvar g = 0; g < 2**SEL_W; g++) begin : g_inc
    localparam longint unsigned INC_V =
      baud_inc(64'(BAUD_RATES[g]), 64'(OVERSAMPLE), ACC_W, 64'(CLK_FREQ));
    assign inc_tbl[g] = INC_V[ACC_W-1:0];
  end

  baud_sel_t       sel_q, sel_d;
  logic [OS_W-1:0] os_idx_q, os_idx_d;
  logic            rx_tick_q, rx_tick_d;
  logic            tx_tick_q, tx_tick_d;
  logic            baud_level_q, baud_level_d;

  logic restart_w;
  logic carry;

  assign restart_w = bus.restart || (bus.baud_sel != sel_q);

  baud_phase_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .arst_n (arst_n),
    .clr    (restart_w),
    .en     (bus.en),
    .inc    (inc_tbl[sel_q]),
    .carry  (carry)
  );

  always_comb begin
    sel_d        = sel_q;
    os_idx_d     = os_idx_q;
    rx_tick_d    = 1'b0;
    tx_tick_d    = 1'b0;
    baud_level_d = baud_level_q;
    if (restart_w) begin
      sel_d    = bus.baud_sel;
      os_idx_d = '0;
    end else if (bus.en && carry) begin
      rx_tick_d = 1'b1;
      os_idx_d  = os_idx_q + 1'b1;  // power-of-two OVERSAMPLE wraps naturally
      if (os_idx_q == OS_LAST) begin
        tx_tick_d    = 1'b1;
        baud_level_d = ~baud_level_q;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sel_q        <= '0;
      os_idx_q     <= '0;
      rx_tick_q    <= 1'b0;
      tx_tick_q    <= 1'b0;
      baud_level_q <= 1'b0;
    end else begin
      sel_q        <= sel_d;
      os_idx_q     <= os_idx_d;
      rx_tick_q    <= rx_tick_d;
      tx_tick_q    <= tx_tick_d;
      baud_level_q <= baud_level_d;
    end
  end

  assign bus.rx_tick    = rx_tick_q;
  assign bus.tx_tick    = tx_tick_q;
  assign bus.os_idx     = os_idx_q;
  assign bus.baud_level = baud_level_q;

endmodule
